block_run_controller: RTL and testbench
=======================================

Name: block_run_controller

Overview:
- Sequences one TIA block through reset, program load, execution and drain, driving the block's reset/enable/execute inputs.
- Monitors the block's registered halted/channels_quiescent/routers_quiescent outputs and declares completion only after all three stay high for a settle window.
- Counts execution cycles and enforces an optional watchdog timeout. Sits between the host command logic and a block instance, one controller per block.

Parameters:
- RESET_CYCLES, 4, cycles block_reset is held high per run (>=1).
- SETTLE_CYCLES, 8, consecutive cycles halted && both quiescent flags must hold before DONE (>=1).
- TIMEOUT_CYCLES, 0, maximum RUNNING+DRAINING cycles; 0 disables the watchdog.
- COUNT_WIDTH, 32, width of cycle_count.

Ports:
- clock  input  1  positive-edge clock
- reset  input  1  synchronous, active-high controller reset
- start  input  1  pulse: begin a run (honoured only in IDLE, DONE, ERROR)
- load_done  input  1  pulse: host finished MMIO program load
- abort  input  1  pulse: terminate the current run
- block_halted  input  1  block halted flag
- block_channels_quiescent  input  1  block channel-quiescence flag
- block_routers_quiescent  input  1  block router-quiescence flag
- block_reset  output  1  drives block reset
- block_enable  output  1  drives block enable
- block_execute  output  1  drives block execute
- state  output  3  current state encoding (run_state_t)
- busy  output  1  high in RESETTING, LOADING, RUNNING, DRAINING
- done  output  1  high in DONE
- timed_out  output  1  high in ERROR
- cycle_count  output  COUNT_WIDTH  cycles spent with block_execute high in this run

Behaviour:
- All outputs are registered. Reset state: IDLE, block_reset=1, block_enable=0, block_execute=0, busy=0, done=0, timed_out=0, cycle_count=0, internal counters=0.
- States: IDLE=0, RESETTING=1, LOADING=2, RUNNING=3, DRAINING=4, DONE=5, ERROR=6.
- IDLE: block_reset=1, enable=0, execute=0. start -> RESETTING.
- RESETTING: block_reset=1. After exactly RESET_CYCLES cycles -> LOADING. cycle_count is cleared on entry.
- LOADING: block_reset=0, enable=1, execute=0; the host writes the program via MMIO. load_done -> RUNNING. A load_done in the same cycle as the RESETTING->LOADING transition is ignored.
- RUNNING: enable=1, execute=1; cycle_count increments every cycle and saturates at all-ones.
  - Once block_halted=1 is seen -> DRAINING.
  - halted is not reliable for the first 2 cycles of RUNNING, because the block's control buffering is 1 cycle in and 1 cycle out. Inputs are ignored for those 2 cycles.
- DRAINING: execute stays 1 and cycle_count keeps counting. A settle counter increments while halted && channels_quiescent && routers_quiescent, and clears to 0 in any cycle where one of them is low. When the counter reaches SETTLE_CYCLES -> DONE.
- DONE: execute=0, enable=1 (results remain readable over MMIO), done=1, cycle_count frozen. start -> RESETTING.
- Watchdog: when TIMEOUT_CYCLES>0, a timer counts cycles in RUNNING+DRAINING. When it reaches TIMEOUT_CYCLES -> ERROR. ERROR: execute=0, enable=1, timed_out=1, cycle_count frozen. start -> RESETTING.
- abort in RESETTING/LOADING/RUNNING/DRAINING -> IDLE next cycle; block_reset reasserts on that edge. abort in IDLE/DONE/ERROR is ignored.
- Simultaneous events, in priority order: reset > abort > timeout > settle-complete > halted/load_done. start in a busy state is ignored.
- Controller reset mid-run forces IDLE and block_reset=1 on the next edge, regardless of state.
- Output transitions coincide with the state register update; there is no added latency beyond 1 cycle from a qualifying input to the new state.

Decomposition:
- Package block_ctrl_pkg: run_state_t enum (3-bit, encodings above) and a localparam for the 2-cycle halt-blanking window.
- One sub-module, quiescence_settle_counter: a saturating consecutive-high counter with parameter SETTLE_CYCLES, inputs clock, reset, clear, level, output settled. Reused for the settle check.

Test Plan:
- Basic run, defaults: start at t0; block_reset low after 4 cycles in RESETTING; load_done; halted+quiescent raised 20 cycles into RUNNING and held -> DRAINING, DONE 8 cycles later, done=1, cycle_count=28, execute=0.
- Settle glitch: in DRAINING, drop routers_quiescent for 1 cycle at settle count 5 -> counter restarts; DONE arrives 8 cycles after the glitch clears.
- Watchdog, TIMEOUT_CYCLES=100: halted never asserted -> ERROR after exactly 100 RUNNING cycles, timed_out=1, cycle_count=100, execute=0.
- Abort in RUNNING at cycle 10 -> IDLE next cycle, block_reset=1, enable=0, busy=0. A later start re-enters RESETTING and clears cycle_count to 0.
- Early halt: block_halted=1 from the first RUNNING cycle -> remains RUNNING for 2 cycles, then DRAINING. start pulses while busy cause no state change.
- Saturation, COUNT_WIDTH=4, TIMEOUT disabled: run 30 cycles -> cycle_count holds at 15. Controller reset asserted mid-DRAINING -> IDLE with all reset values.

Source files
------------

// File: rtl/block_ctrl_pkg.sv
// Shared types for the per-block run controller: run-state encoding and
// the halt-blanking window at the start of execution.
package block_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_RESETTING = 3'd1,
        ST_LOADING   = 3'd2,
        ST_RUNNING   = 3'd3,
        ST_DRAINING  = 3'd4,
        ST_DONE      = 3'd5,
        ST_ERROR     = 3'd6
    } run_state_t;

    // The block buffers control one cycle in and one cycle out, so halted
    // is stale for this many cycles after execute rises.
    localparam int HALT_BLANK_CYCLES = 2;

    function automatic logic is_busy(input run_state_t s);
        return (s == ST_RESETTING) || (s == ST_LOADING) ||
               (s == ST_RUNNING)   || (s == ST_DRAINING);
    endfunction

endpackage

// File: rtl/quiescence_settle_counter.sv
// Counts consecutive cycles with level high; settled marks the cycle in
// which the run of highs reaches SETTLE_CYCLES (and every cycle after).
module quiescence_settle_counter #(
    parameter int SETTLE_CYCLES = 8
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic level,
    output logic settled
);

    localparam int CW = $clog2(SETTLE_CYCLES + 1);

    logic [CW-1:0] count;

    assign settled = level && !clear && (count >= CW'(SETTLE_CYCLES - 1));

    always_ff @(posedge clock) begin
        if (reset || clear || !level)
            count <= '0;
        else if (count != CW'(SETTLE_CYCLES))
            count <= count + CW'(1);
    end

endmodule

// File: rtl/block_run_controller.sv
// Per-block run sequencer: reset -> program load -> execute -> drain, with
// a quiescence settle window, execution cycle counter and optional watchdog.
module block_run_controller
    import block_ctrl_pkg::*;
#(
    parameter int RESET_CYCLES   = 4,
    parameter int SETTLE_CYCLES  = 8,
    parameter int TIMEOUT_CYCLES = 0,
    parameter int COUNT_WIDTH    = 32
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   load_done,
    input  logic                   abort,
    input  logic                   block_halted,
    input  logic                   block_channels_quiescent,
    input  logic                   block_routers_quiescent,
    output logic                   block_reset,
    output logic                   block_enable,
    output logic                   block_execute,
    output run_state_t             state,
    output logic                   busy,
    output logic                   done,
    output logic                   timed_out,
    output logic [COUNT_WIDTH-1:0] cycle_count
);

    localparam int PW = $clog2(RESET_CYCLES + HALT_BLANK_CYCLES + 1);
    localparam int WW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    run_state_t    next_state;
    logic [PW-1:0] phase_cnt;
    logic [WW-1:0] wd_cnt;
    logic          in_exec;
    logic          wd_expire;
    logic          settle_clear;
    logic          settle_level;
    logic          settled;

    assign in_exec      = (state == ST_RUNNING) || (state == ST_DRAINING);
    assign wd_expire    = (TIMEOUT_CYCLES > 0) && in_exec &&
                          (wd_cnt == WW'(TIMEOUT_CYCLES - 1));
    assign settle_clear = (state != ST_DRAINING);
    assign settle_level = block_halted && block_channels_quiescent &&
                          block_routers_quiescent;

    quiescence_settle_counter #(
        .SETTLE_CYCLES(SETTLE_CYCLES)
    ) u_settle (
        .clock  (clock),
        .reset  (reset),
        .clear  (settle_clear),
        .level  (settle_level),
        .settled(settled)
    );

    // Branch order within each state encodes abort > timeout > settle > halted/load_done.
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:      if (start) next_state = ST_RESETTING;
            ST_RESETTING: begin
                if (abort)                                   next_state = ST_IDLE;
                else if (phase_cnt == PW'(RESET_CYCLES - 1)) next_state = ST_LOADING;
            end
            ST_LOADING: begin
                if (abort)          next_state = ST_IDLE;
                else if (load_done) next_state = ST_RUNNING;
            end
            ST_RUNNING: begin
                if (abort)          next_state = ST_IDLE;
                else if (wd_expire) next_state = ST_ERROR;
                else if (block_halted && phase_cnt >= PW'(HALT_BLANK_CYCLES))
                    next_state = ST_DRAINING;
            end
            ST_DRAINING: begin
                if (abort)          next_state = ST_IDLE;
                else if (wd_expire) next_state = ST_ERROR;
                else if (settled)   next_state = ST_DONE;
            end
            ST_DONE, ST_ERROR: if (start) next_state = ST_RESETTING;
            default:           next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= ST_IDLE;
            block_reset   <= 1'b1;
            block_enable  <= 1'b0;
            block_execute <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            timed_out     <= 1'b0;
            cycle_count   <= '0;
            phase_cnt     <= '0;
            wd_cnt        <= '0;
        end else begin
            state         <= next_state;
            block_reset   <= (next_state == ST_IDLE) || (next_state == ST_RESETTING);
            block_enable  <= (next_state != ST_IDLE) && (next_state != ST_RESETTING);
            block_execute <= (next_state == ST_RUNNING) || (next_state == ST_DRAINING);
            busy          <= is_busy(next_state);
            done          <= (next_state == ST_DONE);
            timed_out     <= (next_state == ST_ERROR);

            if (next_state != state)
                phase_cnt <= '0;
            else if (phase_cnt != '1)
                phase_cnt <= phase_cnt + PW'(1);

            // Counters restart with each run and freeze outside execution.
            if (next_state == ST_RESETTING && state != ST_RESETTING) begin
                cycle_count <= '0;
                wd_cnt      <= '0;
            end else if (in_exec) begin
                if (cycle_count != '1)
                    cycle_count <= cycle_count + COUNT_WIDTH'(1);
                if (TIMEOUT_CYCLES > 0)
                    wd_cnt <= wd_cnt + WW'(1);
            end
        end
    end

endmodule

// File: tb/tb_block_run_controller.sv
// Bench for block_run_controller: three parameterisations share stimulus;
// directed table, hand sequences and a randomized run against a phase model.
module tb_block_run_controller;
    import block_ctrl_pkg::*;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic reset, start, load_done, abort, halted, chq, rtq;

    logic a_brst, a_ben, a_bex, a_busy, a_done, a_to;
    logic w_brst, w_ben, w_bex, w_busy, w_done, w_to;
    logic s_brst, s_ben, s_bex, s_busy, s_done, s_to;
    logic [2:0]  a_state, w_state, s_state;
    logic [31:0] a_cnt, w_cnt;
    logic [3:0]  s_cnt;

    block_run_controller dut_a (
        .clock(clock), .reset(reset), .start(start), .load_done(load_done), .abort(abort),
        .block_halted(halted), .block_channels_quiescent(chq), .block_routers_quiescent(rtq),
        .block_reset(a_brst), .block_enable(a_ben), .block_execute(a_bex), .state(a_state),
        .busy(a_busy), .done(a_done), .timed_out(a_to), .cycle_count(a_cnt));

    block_run_controller #(.TIMEOUT_CYCLES(100)) dut_w (
        .clock(clock), .reset(reset), .start(start), .load_done(load_done), .abort(abort),
        .block_halted(halted), .block_channels_quiescent(chq), .block_routers_quiescent(rtq),
        .block_reset(w_brst), .block_enable(w_ben), .block_execute(w_bex), .state(w_state),
        .busy(w_busy), .done(w_done), .timed_out(w_to), .cycle_count(w_cnt));

    block_run_controller #(.COUNT_WIDTH(4)) dut_s (
        .clock(clock), .reset(reset), .start(start), .load_done(load_done), .abort(abort),
        .block_halted(halted), .block_channels_quiescent(chq), .block_routers_quiescent(rtq),
        .block_reset(s_brst), .block_enable(s_ben), .block_execute(s_bex), .state(s_state),
        .busy(s_busy), .done(s_done), .timed_out(s_to), .cycle_count(s_cnt));

    typedef struct packed {
        logic [2:0]  st;
        logic        brst, ben, bex, busy, done, tmo;
        logic [31:0] cnt;
    } obs_t;

    typedef struct {
        logic [5:0] in;   // {start, load_done, abort, halted, chq, rtq}
        int         ncyc;
        int         eph;
        int         ecnt;
    } vec_t;

    int n_cmp = 0;
    int n_bad = 0;

    // Phase model: 0 idle, 1 resetting, 2 loading, 3 running, 4 draining, 5 done, 6 error
    localparam int RST_C = 4;
    localparam int SET_C = 8;
    int     to_c[3] = '{0, 100, 0};
    int     w_c[3]  = '{32, 32, 4};
    int     m_ph[3];
    int     m_age[3];
    int     m_settle[3];
    longint m_exec[3];

    function automatic void mstep(input int k);
        int nph;
        nph = m_ph[k];
        if (reset) begin
            m_ph[k] = 0; m_age[k] = 0; m_settle[k] = 0; m_exec[k] = 0;
            return;
        end
        case (m_ph[k])
            0: if (start) nph = 1;
            1: if (abort) nph = 0; else if (m_age[k] == RST_C - 1) nph = 2;
            2: if (abort) nph = 0; else if (load_done) nph = 3;
            3, 4: begin
                m_exec[k]++;
                if (m_ph[k] == 4) m_settle[k] = (halted && chq && rtq) ? m_settle[k] + 1 : 0;
                if (abort)                                    nph = 0;
                else if (to_c[k] > 0 && m_exec[k] == to_c[k]) nph = 6;
                else if (m_ph[k] == 4 && m_settle[k] >= SET_C) nph = 5;
                else if (m_ph[k] == 3 && m_age[k] >= 2 && halted) nph = 4;
            end
            default: if (start) nph = 1;
        endcase
        if (nph == 1 && m_ph[k] != 1) m_exec[k] = 0;
        if (nph != 4) m_settle[k] = 0;
        m_age[k] = (nph == m_ph[k]) ? m_age[k] + 1 : 0;
        m_ph[k]  = nph;
    endfunction

    function automatic longint mcnt(input int k);
        longint mx;
        mx = (longint'(1) <<< w_c[k]) - 1;
        return (m_exec[k] > mx) ? mx : m_exec[k];
    endfunction

    function automatic obs_t exp_obs(input int ph, input longint cnt);
        obs_t o;
        o.st   = 3'(ph);
        o.brst = (ph <= 1);
        o.ben  = (ph >= 2);
        o.bex  = (ph == 3) || (ph == 4);
        o.busy = (ph >= 1) && (ph <= 4);
        o.done = (ph == 5);
        o.tmo  = (ph == 6);
        o.cnt  = 32'(cnt);
        return o;
    endfunction

    function automatic obs_t get_obs(input int k);
        obs_t o;
        case (k)
            0:       o = {a_state, a_brst, a_ben, a_bex, a_busy, a_done, a_to, a_cnt};
            1:       o = {w_state, w_brst, w_ben, w_bex, w_busy, w_done, w_to, w_cnt};
            default: o = {s_state, s_brst, s_ben, s_bex, s_busy, s_done, s_to, 28'd0, s_cnt};
        endcase
        return o;
    endfunction

    task automatic chk(input string name, input obs_t act, input obs_t exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got st=%0d rst=%b en=%b ex=%b busy=%b done=%b to=%b cnt=%0d, want st=%0d rst=%b en=%b ex=%b busy=%b done=%b to=%b cnt=%0d",
                     name, act.st, act.brst, act.ben, act.bex, act.busy, act.done, act.tmo, act.cnt,
                     exp.st, exp.brst, exp.ben, exp.bex, exp.busy, exp.done, exp.tmo, exp.cnt);
        end
    endtask

    task automatic tick();
        for (int k = 0; k < 3; k++) mstep(k);
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; start = 1'b0; load_done = 1'b0; abort = 1'b0;
        halted = 1'b0; chq = 1'b0; rtq = 1'b0;
        tick(); tick();
        reset = 1'b0;
    endtask

    task automatic run_to_running();
        start = 1'b1; tick(); start = 1'b0;
        repeat (RST_C) tick();
        load_done = 1'b1; tick(); load_done = 1'b0;
    endtask

    vec_t tbl[21];
    bit   h_l, c_l, r_l;
    obs_t o;

    initial begin
        tbl[0]  = '{6'b100000, 1,  1, 0};
        tbl[1]  = '{6'b000000, 3,  1, 0};
        tbl[2]  = '{6'b000000, 1,  2, 0};
        tbl[3]  = '{6'b010000, 1,  3, 0};
        tbl[4]  = '{6'b000000, 19, 3, 19};
        tbl[5]  = '{6'b000111, 1,  4, 20};
        tbl[6]  = '{6'b000111, 7,  4, 27};
        tbl[7]  = '{6'b000111, 1,  5, 28};
        tbl[8]  = '{6'b000111, 3,  5, 28};
        tbl[9]  = '{6'b100111, 1,  1, 0};
        tbl[10] = '{6'b000000, 3,  1, 0};
        tbl[11] = '{6'b010000, 1,  2, 0};
        tbl[12] = '{6'b000000, 2,  2, 0};
        tbl[13] = '{6'b010000, 1,  3, 0};
        tbl[14] = '{6'b000111, 2,  3, 2};
        tbl[15] = '{6'b000111, 1,  4, 3};
        tbl[16] = '{6'b100111, 5,  4, 8};
        tbl[17] = '{6'b000110, 1,  4, 9};
        tbl[18] = '{6'b000111, 7,  4, 16};
        tbl[19] = '{6'b000111, 1,  5, 17};
        tbl[20] = '{6'b001111, 2,  5, 17};

        do_reset();
        for (int k = 0; k < 3; k++)
            chk($sformatf("reset_dut%0d", k), get_obs(k), exp_obs(0, 0));

        for (int r = 0; r < 21; r++) begin
            for (int c = 0; c < tbl[r].ncyc; c++) begin
                start     = tbl[r].in[5] && (c == 0);
                load_done = tbl[r].in[4] && (c == 0);
                abort     = tbl[r].in[3] && (c == 0);
                halted    = tbl[r].in[2];
                chq       = tbl[r].in[1];
                rtq       = tbl[r].in[0];
                tick();
            end
            start = 1'b0; load_done = 1'b0; abort = 1'b0;
            chk($sformatf("vec%0d", r), get_obs(0), exp_obs(tbl[r].eph, tbl[r].ecnt));
        end

        // Watchdog on dut_w; dut_a (no watchdog) keeps running.
        do_reset();
        run_to_running();
        repeat (99) tick();
        chk("wd_before", get_obs(1), exp_obs(3, 99));
        tick();
        chk("wd_expire", get_obs(1), exp_obs(6, 100));
        repeat (3) tick();
        chk("wd_frozen", get_obs(1), exp_obs(6, 100));
        chk("wd_disabled", get_obs(0), exp_obs(3, 103));
        start = 1'b1; tick(); start = 1'b0;
        chk("wd_restart", get_obs(1), exp_obs(1, 0));

        // Abort mid-run; count retention after abort is not pinned down, so mask it.
        do_reset();
        run_to_running();
        repeat (10) tick();
        abort = 1'b1; tick(); abort = 1'b0;
        o = get_obs(0); o.cnt = '0;
        chk("abort_idle", o, exp_obs(0, 0));
        start = 1'b1; tick(); start = 1'b0;
        chk("abort_restart", get_obs(0), exp_obs(1, 0));

        // Saturation on the 4-bit counter, then controller reset mid-drain.
        do_reset();
        run_to_running();
        repeat (30) tick();
        chk("sat_hold", get_obs(2), exp_obs(3, 15));
        halted = 1'b1; chq = 1'b1; rtq = 1'b1;
        repeat (3) tick();
        chk("sat_drain", get_obs(2), exp_obs(4, 15));
        reset = 1'b1; tick(); reset = 1'b0;
        chk("midrun_reset_s", get_obs(2), exp_obs(0, 0));
        chk("midrun_reset_a", get_obs(0), exp_obs(0, 0));

        // Randomized run against the phase model.
        do_reset();
        h_l = 1'b0; c_l = 1'b1; r_l = 1'b1;
        for (int i = 0; i < 2000; i++) begin
            reset     = ($urandom_range(0, 199) == 0);
            start     = ($urandom_range(0, 9) == 0);
            load_done = ($urandom_range(0, 4) == 0);
            abort     = ($urandom_range(0, 59) == 0);
            if ($urandom_range(0, 11) == 0) h_l = !h_l;
            if ($urandom_range(0, 15) == 0) c_l = !c_l;
            if ($urandom_range(0, 15) == 0) r_l = !r_l;
            halted = h_l; chq = c_l; rtq = r_l;
            tick();
            for (int k = 0; k < 3; k++)
                chk($sformatf("rand%0d_dut%0d", i, k), get_obs(k), exp_obs(m_ph[k], mcnt(k)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
